txmux_sel: RTL and testbench
============================

# txmux_sel

Registered, per-channel transmit source multiplexer driving the 2×LINKS serializer-side block interfaces. Each channel independently selects mission data, a BIST engine stream, or far-end loopback data. Source changes are hitless: the channel inserts a programmable run of idle control blocks before adopting the new source, so the PCS never sees a torn block. It sits between the BIST engines / link MACs / RX loopback path and the transceiver TX block interface.

## Interface

Parameters:
- LINKS, 12, link count; channel count CH = 2*LINKS.
- NBIST, 2, number of txbist engines; channel c is served by engine c % NBIST.
- IDLE_CYC, 4, idle blocks inserted on each source change (1..255).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- txbist_data  in  [NBIST][72]  BIST stream; [63:0] block, [65:64] sync header, [71:66] ignored.
- txbist_data_val  in  [NBIST]  BIST block valid.
- mis_blk / mis_sh / mis_val  in  [CH][64] / [CH][2] / [CH]  mission data per channel.
- lpbk_blk / lpbk_sh / lpbk_val  in  [CH][64] / [CH][2] / [CH]  far-end loopback data per channel.
- cfg_sel  in  [CH][2]  requested source: 0 mission, 1 BIST, 2 loopback, 3 quiet (val held 0).
- tx_blk  out  [CH][64]  output block.
- tx_sh  out  [CH][2]  output sync header.
- tx_val  out  [CH]  output valid.
- sel_act  out  [CH][2]  source currently driving the channel.
- sw_busy  out  [CH]  channel is inserting idles for a source change.

## Operation

- Per channel, a 2-state FSM: RUN, FILL. Also per channel: registered act_sel (2 b) and idle counter cnt (8 b).
- RUN: output = source indexed by act_sel, registered. If cfg_sel != act_sel, go to FILL, load cnt = IDLE_CYC-1; the triggering cycle already emits an idle block.
- FILL: emits idle block each cycle: tx_blk = 64'h0000_0000_0000_001E, tx_sh = 2'b10, tx_val = 1. cnt decrements each cycle. When cnt == 0, act_sel <= cfg_sel sampled that cycle and state goes to RUN; the next cycle carries the new source.
- cfg_sel changing again during FILL does not restart the count; the value sampled on the final FILL cycle wins. If that value equals the old act_sel, the channel still returns to RUN (idles remain inserted).
- Target quiet (3): idles are still inserted; then tx_val = 0, tx_blk = 0, tx_sh = 0.
- Source val = 0 in RUN: tx_val = 0, with tx_blk/tx_sh passing the source data unqualified.
- BIST mapping is fixed: channel c uses txbist_data[c % NBIST], and 72-bit bits [71:66] are never forwarded.
- sw_busy = (state == FILL). sel_act = act_sel.
- Channels are fully independent; no shared state beyond the BIST fan-out.

## Timing

- Latency: 1 clk from any data input to tx_* in RUN.
- Reset: all channels in RUN, act_sel = 3 (quiet), cnt = 0, tx_blk = 0, tx_sh = 0, tx_val = 0, sel_act = 3, sw_busy = 0. If cfg_sel != 3 after reset, a normal FILL sequence follows. This guarantees idles precede first traffic.
- Switch: with cfg_sel changed in cycle t (RUN), outputs at t+1 .. t+IDLE_CYC are idle blocks; the first new-source block appears at t+IDLE_CYC+1.
- sel_act updates on the same edge as the first new-source output. sw_busy is high on exactly IDLE_CYC output cycles.
- rst asserted mid-FILL: the next edge forces reset values, and the count is discarded.
- Reset has priority over every other event on the same edge.

## Test plan

- Reset: hold rst 3 clk with all inputs random -> all tx_val = 0, tx_blk = 0, sel_act = 3, sw_busy = 0. Release with cfg_sel = 0 -> 4 idle blocks (blk 0x1E, sh 2'b10, val 1), then mission data 1 clk late.
- BIST fan-out: NBIST = 3, LINKS = 3, all cfg_sel = 1, engine k drives blk = k, val = 1 -> channels 0..5 show 0,1,2,0,1,2, and sh equals the engine's [65:64].
- Hitless switch: channel 5 in mission, counter pattern; set cfg_sel[5] = 2 at t -> exactly IDLE_CYC idles at t+1.., loopback data from t+IDLE_CYC+1, other channels unaffected.
- Reselect during FILL: IDLE_CYC = 8; request 1, then 2 three cycles later -> 8 idles total, then loopback, sel_act = 2.
- Quiet and invalid: cfg_sel = 3 -> idles then tx_val = 0, blk = 0. In mission with mis_val toggling 1,0,1 -> tx_val 1,0,1 delayed 1 clk.
- Reset mid-FILL: assert rst on 2nd idle -> next cycle reset values, no residual idles before the new sequence.

Source files
------------

// File: rtl/txmux_sel.sv
// Per-channel TX source mux (mission / BIST / loopback / quiet). A source change is hitless:
// the channel emits a run of IDLE_CYC idle control blocks before it adopts the new source.

module txmux_sel_ch #(
   parameter int IDLE_CYC = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  cfg_sel_i,
   input  logic [63:0] mis_blk_i,
   input  logic [1:0]  mis_sh_i,
   input  logic        mis_val_i,
   input  logic [63:0] bist_blk_i,
   input  logic [1:0]  bist_sh_i,
   input  logic        bist_val_i,
   input  logic [63:0] lpbk_blk_i,
   input  logic [1:0]  lpbk_sh_i,
   input  logic        lpbk_val_i,
   output logic [63:0] tx_blk_o,
   output logic [1:0]  tx_sh_o,
   output logic        tx_val_o,
   output logic [1:0]  sel_act_o,
   output logic        sw_busy_o
);
   typedef enum logic {RUN, FILL} state_t;

   localparam logic [7:0]  IDLE_LD  = 8'(IDLE_CYC - 1);
   localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  act_q;
   logic [63:0] blk_q;
   logic [1:0]  sh_q;
   logic        val_q;

   logic [1:0]  src_d;
   logic [63:0] blk_d;
   logic [1:0]  sh_d;
   logic        val_d;

   // On the last FILL cycle the freshly sampled request already steers the data path.
   always_comb begin
      src_d = (state_q == FILL) ? cfg_sel_i : act_q;
      blk_d = '0;
      sh_d  = '0;
      val_d = 1'b0;
      case (src_d)
         2'd0:    begin blk_d = mis_blk_i;  sh_d = mis_sh_i;  val_d = mis_val_i;  end
         2'd1:    begin blk_d = bist_blk_i; sh_d = bist_sh_i; val_d = bist_val_i; end
         2'd2:    begin blk_d = lpbk_blk_i; sh_d = lpbk_sh_i; val_d = lpbk_val_i; end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
         act_q   <= 2'd3;
         blk_q   <= '0;
         sh_q    <= '0;
         val_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (cfg_sel_i != act_q) begin
                  state_q <= FILL;
                  cnt_q   <= IDLE_LD;
                  blk_q   <= IDLE_BLK;
                  sh_q    <= 2'b10;
                  val_q   <= 1'b1;
               end else begin
                  blk_q   <= blk_d;
                  sh_q    <= sh_d;
                  val_q   <= val_d;
               end
            end
            FILL: begin
               if (cnt_q == 8'd0) begin
                  state_q <= RUN;
                  act_q   <= cfg_sel_i;
                  blk_q   <= blk_d;
                  sh_q    <= sh_d;
                  val_q   <= val_d;
               end else begin
                  cnt_q   <= cnt_q - 8'd1;
                  blk_q   <= IDLE_BLK;
                  sh_q    <= 2'b10;
                  val_q   <= 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign tx_blk_o  = blk_q;
   assign tx_sh_o   = sh_q;
   assign tx_val_o  = val_q;
   assign sel_act_o = act_q;
   assign sw_busy_o = (state_q == FILL);
endmodule

module txmux_sel #(
   parameter int LINKS    = 12,
   parameter int NBIST    = 2,
   parameter int IDLE_CYC = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NBIST-1:0][71:0]      txbist_data,
   input  logic [NBIST-1:0]            txbist_data_val,
   input  logic [2*LINKS-1:0][63:0]    mis_blk,
   input  logic [2*LINKS-1:0][1:0]     mis_sh,
   input  logic [2*LINKS-1:0]          mis_val,
   input  logic [2*LINKS-1:0][63:0]    lpbk_blk,
   input  logic [2*LINKS-1:0][1:0]     lpbk_sh,
   input  logic [2*LINKS-1:0]          lpbk_val,
   input  logic [2*LINKS-1:0][1:0]     cfg_sel,
   output logic [2*LINKS-1:0][63:0]    tx_blk,
   output logic [2*LINKS-1:0][1:0]     tx_sh,
   output logic [2*LINKS-1:0]          tx_val,
   output logic [2*LINKS-1:0][1:0]     sel_act,
   output logic [2*LINKS-1:0]          sw_busy
);
   localparam int CH = 2 * LINKS;

   // Upper BIST word bits carry engine-side metadata that never reaches the PCS.
   logic [NBIST-1:0][5:0] unused_bist_hi;
   for (genvar k = 0; k < NBIST; k++) begin : g_bhi
      assign unused_bist_hi[k] = txbist_data[k][71:66];
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      localparam int B = c % NBIST;
      txmux_sel_ch #(.IDLE_CYC(IDLE_CYC)) u_ch (
         .clk_i      (clk),
         .rst_i      (rst),
         .cfg_sel_i  (cfg_sel[c]),
         .mis_blk_i  (mis_blk[c]),
         .mis_sh_i   (mis_sh[c]),
         .mis_val_i  (mis_val[c]),
         .bist_blk_i (txbist_data[B][63:0]),
         .bist_sh_i  (txbist_data[B][65:64]),
         .bist_val_i (txbist_data_val[B]),
         .lpbk_blk_i (lpbk_blk[c]),
         .lpbk_sh_i  (lpbk_sh[c]),
         .lpbk_val_i (lpbk_val[c]),
         .tx_blk_o   (tx_blk[c]),
         .tx_sh_o    (tx_sh[c]),
         .tx_val_o   (tx_val[c]),
         .sel_act_o  (sel_act[c]),
         .sw_busy_o  (sw_busy[c])
      );
   end
endmodule

// File: tb/tb_txmux_sel.sv
// Directed bench for txmux_sel: reset, BIST fan-out, hitless switch, reselect in FILL,
// quiet/invalid data and reset during FILL.

module tb_txmux_sel;
   localparam int LINKS = 3;
   localparam int NBIST = 3;
   localparam int IDLE  = 4;
   localparam int CH    = 2 * LINKS;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NBIST-1:0][71:0] txbist_data;
   logic [NBIST-1:0]       txbist_data_val;
   logic [CH-1:0][63:0]    mis_blk, lpbk_blk, tx_blk;
   logic [CH-1:0][1:0]     mis_sh, lpbk_sh, cfg_sel, tx_sh, sel_act;
   logic [CH-1:0]          mis_val, lpbk_val, tx_val, sw_busy;

   int n_cmp = 0;
   int n_err = 0;
   int n     = 0;

   always #5 clk = ~clk;

   txmux_sel #(.LINKS(LINKS), .NBIST(NBIST), .IDLE_CYC(IDLE)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .txbist_data     (txbist_data),
      .txbist_data_val (txbist_data_val),
      .mis_blk         (mis_blk),
      .mis_sh          (mis_sh),
      .mis_val         (mis_val),
      .lpbk_blk        (lpbk_blk),
      .lpbk_sh         (lpbk_sh),
      .lpbk_val        (lpbk_val),
      .cfg_sel         (cfg_sel),
      .tx_blk          (tx_blk),
      .tx_sh           (tx_sh),
      .tx_val          (tx_val),
      .sel_act         (sel_act),
      .sw_busy         (sw_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mis_pat(input int c, input int k);
      return {32'h4D15_0000 + 32'(c), 32'(k)};
   endfunction

   function automatic logic [63:0] lpbk_pat(input int c, input int k);
      return {32'h1B00_0000 + 32'(c), 32'(k)};
   endfunction

   task automatic drive(input int k);
      for (int c = 0; c < CH; c++) begin
         mis_blk[c]  = mis_pat(c, k);
         lpbk_blk[c] = lpbk_pat(c, k);
      end
   endtask

   task automatic chk_idle(input string tag, input int c);
      chk({tag, "_blk"},  tx_blk[c],  64'h1E);
      chk({tag, "_sh"},   tx_sh[c],   64'd2);
      chk({tag, "_val"},  tx_val[c],  64'd1);
      chk({tag, "_busy"}, sw_busy[c], 64'd1);
   endtask

   // Steps through the IDLE idle outputs of channel c while refreshing data.
   task automatic run_idles(input string tag, input int c);
      for (int i = 0; i < IDLE; i++) begin
         drive(n);
         step();
         chk_idle(tag, c);
         n++;
      end
   endtask

   initial begin
      // reset with random inputs
      rst = 1'b1;
      for (int k = 0; k < NBIST; k++) txbist_data[k] = {$urandom, $urandom, $urandom};
      txbist_data_val = NBIST'($urandom);
      for (int c = 0; c < CH; c++) begin
         mis_blk[c]  = {$urandom, $urandom};
         lpbk_blk[c] = {$urandom, $urandom};
         mis_sh[c]   = 2'($urandom);
         lpbk_sh[c]  = 2'($urandom);
         cfg_sel[c]  = 2'($urandom);
      end
      mis_val  = CH'($urandom);
      lpbk_val = CH'($urandom);
      repeat (3) step();
      for (int c = 0; c < CH; c++) begin
         chk("rst_val",  tx_val[c],  0);
         chk("rst_blk",  tx_blk[c],  0);
         chk("rst_sel",  sel_act[c], 3);
         chk("rst_busy", sw_busy[c], 0);
      end

      // release into mission: idles first, then data one clock late
      rst = 1'b0;
      for (int c = 0; c < CH; c++) begin
         cfg_sel[c] = 2'd0;
         mis_sh[c]  = 2'b01;
         lpbk_sh[c] = 2'b11;
      end
      mis_val  = '1;
      lpbk_val = '1;
      run_idles("rel_idle", 0);
      drive(n);
      step();
      chk("rel_blk",  tx_blk[0],  mis_pat(0, n));
      chk("rel_sh",   tx_sh[0],   1);
      chk("rel_val",  tx_val[0],  1);
      chk("rel_sel",  sel_act[0], 0);
      chk("rel_busy", sw_busy[0], 0);
      n++;

      // BIST fan-out, bits [71:66] set to ones and expected to vanish
      for (int k = 0; k < NBIST; k++) txbist_data[k] = {6'h3F, 2'(k + 1), 64'h0B00 + 64'(k)};
      txbist_data_val = '1;
      for (int c = 0; c < CH; c++) cfg_sel[c] = 2'd1;
      run_idles("bist_idle", 3);
      step();
      for (int c = 0; c < CH; c++) begin
         chk("bist_blk", tx_blk[c],  64'h0B00 + 64'(c % NBIST));
         chk("bist_sh",  tx_sh[c],   64'((c % NBIST) + 1));
         chk("bist_val", tx_val[c],  1);
         chk("bist_sel", sel_act[c], 1);
      end

      // back to mission, then hitless switch of channel 5 to loopback
      for (int c = 0; c < CH; c++) cfg_sel[c] = 2'd0;
      run_idles("mis_idle", 5);
      drive(n);
      step();
      chk("mis_blk5", tx_blk[5], mis_pat(5, n));
      n++;
      cfg_sel[5] = 2'd2;
      for (int i = 0; i < IDLE; i++) begin
         drive(n);
         step();
         chk_idle("sw_idle", 5);
         chk("sw_sel_old", sel_act[5], 0);
         chk("sw_other",   tx_blk[4],  mis_pat(4, n));
         n++;
      end
      drive(n);
      step();
      chk("sw_blk",  tx_blk[5],  lpbk_pat(5, n));
      chk("sw_sh",   tx_sh[5],   3);
      chk("sw_sel",  sel_act[5], 2);
      chk("sw_busy", sw_busy[5], 0);
      n++;

      // reselect during FILL: count is not restarted, last request wins
      cfg_sel[4] = 2'd1;
      for (int i = 0; i < IDLE; i++) begin
         if (i == 2) cfg_sel[4] = 2'd2;
         drive(n);
         step();
         chk_idle("rs_idle", 4);
         n++;
      end
      drive(n);
      step();
      chk("rs_blk",  tx_blk[4],  lpbk_pat(4, n));
      chk("rs_sel",  sel_act[4], 2);
      chk("rs_busy", sw_busy[4], 0);
      n++;

      // quiet target
      cfg_sel[3] = 2'd3;
      run_idles("q_idle", 3);
      drive(n);
      step();
      chk("q_val", tx_val[3],  0);
      chk("q_blk", tx_blk[3],  0);
      chk("q_sh",  tx_sh[3],   0);
      chk("q_sel", sel_act[3], 3);
      n++;

      // mission valid toggling, data passes unqualified
      for (int i = 0; i < 3; i++) begin
         mis_val[0] = (i != 1);
         drive(n);
         step();
         chk("inv_val", tx_val[0], 64'(i != 1));
         chk("inv_blk", tx_blk[0], mis_pat(0, n));
         n++;
      end
      mis_val[0] = 1'b1;

      // reset while channel 1 is on its second idle
      cfg_sel[1] = 2'd1;
      step();
      chk_idle("mf_idle1", 1);
      step();
      chk_idle("mf_idle2", 1);
      rst = 1'b1;
      step();
      chk("mf_rst_val",  tx_val[1],  0);
      chk("mf_rst_blk",  tx_blk[1],  0);
      chk("mf_rst_busy", sw_busy[1], 0);
      chk("mf_rst_sel",  sel_act[1], 3);
      rst = 1'b0;
      run_idles("mf_new_idle", 1);
      step();
      chk("mf_blk",  tx_blk[1],  64'h0B01);
      chk("mf_sel",  sel_act[1], 1);
      chk("mf_busy", sw_busy[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
